// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolution unit: jump-type bit positions,
// BHT counter encodings and the BTB entry layout.
package bru_pkg;

    localparam int JT_JAL  = 0;
    localparam int JT_JALR = 1;
    localparam int JT_BEQ  = 2;
    localparam int JT_BNE  = 3;
    localparam int JT_BLT  = 4;
    localparam int JT_BGE  = 5;
    localparam int JT_BLTU = 6;
    localparam int JT_BGEU = 7;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    // Fields are sized for the widest supported configuration; narrower
    // instances zero-extend tag and target into them.
    localparam int BTB_TAG_MAX = 32;
    localparam int BTB_TGT_MAX = 64;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic [BTB_TGT_MAX-1:0] target;
        logic                   uncond;
    } btb_entry_t;

    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        if (taken) return (cur == BHT_ST)  ? BHT_ST  : cur + 2'd1;
        else       return (cur == BHT_SNT) ? BHT_SNT : cur - 2'd1;
    endfunction

endpackage

// File: rtl/bru_btb.sv
// BTB + BHT storage: one combinational read port for fetch, one synchronous
// write port for resolved branches, cleared by reset.
module bru_btb
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_hit,
    output logic             rd_uncond,
    output logic [1:0]       rd_ctr,
    output logic [XLEN-1:0]  rd_target,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_set,
    input  logic [XLEN-1:0]  wr_target,
    input  logic             wr_uncond,
    input  logic             wr_inval,
    input  logic             bht_upd,
    input  logic             bht_taken
);

    btb_entry_t btb [DEPTH];
    logic [1:0] bht [DEPTH];

    btb_entry_t rd_e;
    assign rd_e      = btb[rd_idx];
    assign rd_hit    = rd_e.valid && (rd_e.tag == BTB_TAG_MAX'(rd_tag));
    assign rd_uncond = rd_e.uncond;
    assign rd_target = rd_e.target[XLEN-1:0];
    assign rd_ctr    = bht[rd_idx];

    // upper target bits are zero padding
    logic unused_rd;
    assign unused_rd = ^rd_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i] <= '0;
                bht[i] <= BHT_WNT;
            end
        end else begin
            if (wr_set) begin
                btb[wr_idx] <= '{valid:  1'b1,
                                 tag:    BTB_TAG_MAX'(wr_tag),
                                 target: BTB_TGT_MAX'(wr_target),
                                 uncond: wr_uncond};
            end else if (wr_inval && btb[wr_idx].valid &&
                         btb[wr_idx].tag == BTB_TAG_MAX'(wr_tag)) begin
                btb[wr_idx].valid <= 1'b0;
            end
            if (bht_upd) bht[wr_idx] <= bht_next(bht[wr_idx], bht_taken);
        end
    end

endmodule

// File: rtl/bru_bp.sv
// Branch resolution unit with BHT/BTB prediction, registered mispredict
// redirect and event counters.
module bru_bp
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int TAG_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [XLEN-1:0] if_pred_target,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [7:0]      ex_jump_type,
    input  logic [XLEN-1:0] ex_src1,
    input  logic [XLEN-1:0] ex_src2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     perf_br_cnt,
    output logic [31:0]     perf_miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_LO = IDX_W + 2;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[TAG_LO+TAG_W-1:TAG_LO];

    logic unused_if_pc;
    assign unused_if_pc = ^if_pc;

    logic            rd_hit, rd_uncond;
    logic [1:0]      rd_ctr;
    logic [XLEN-1:0] rd_target;

    assign if_pred_taken  = rd_hit && (rd_uncond || rd_ctr[1]);
    assign if_pred_target = if_pred_taken ? rd_target : '0;

    // One subtract yields eq, unsigned borrow and the signed compare.
    logic [XLEN:0] diff;
    logic          eq, lt, ltu;
    assign diff = {1'b0, ex_src1} - {1'b0, ex_src2};
    assign eq   = (diff[XLEN-1:0] == '0);
    assign ltu  = diff[XLEN];
    assign lt   = (ex_src1[XLEN-1] ^ ex_src2[XLEN-1]) ? ex_src1[XLEN-1] : diff[XLEN-1];

    logic is_uncond, is_cond, is_ctrl, taken, mispred, resolve;
    logic [XLEN-1:0] target, next_pc;

    assign is_uncond = ex_jump_type[JT_JAL] | ex_jump_type[JT_JALR];
    assign is_cond   = |ex_jump_type[JT_BGEU:JT_BEQ];
    assign is_ctrl   = is_uncond | is_cond;

    assign taken = is_uncond
                 | (ex_jump_type[JT_BEQ]  &  eq)
                 | (ex_jump_type[JT_BNE]  & ~eq)
                 | (ex_jump_type[JT_BLT]  &  lt)
                 | (ex_jump_type[JT_BGE]  & ~lt)
                 | (ex_jump_type[JT_BLTU] &  ltu)
                 | (ex_jump_type[JT_BGEU] & ~ltu);

    assign target  = ex_jump_type[JT_JALR] ? ((ex_src1 + ex_imm) & ~XLEN'(1))
                                           : (ex_pc + ex_imm);
    assign next_pc = taken ? target : ex_pc + XLEN'(4);
    assign mispred = (taken != ex_pred_taken) || (taken && (target != ex_pred_target));
    assign resolve = ex_valid && !ex_flush;

    bru_btb #(
        .XLEN  (XLEN),
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_idx),
        .rd_tag    (if_tag),
        .rd_hit    (rd_hit),
        .rd_uncond (rd_uncond),
        .rd_ctr    (rd_ctr),
        .rd_target (rd_target),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_set    (resolve && taken),
        .wr_target (target),
        .wr_uncond (is_uncond),
        .wr_inval  (resolve && !is_ctrl),
        .bht_upd   (resolve && is_cond),
        .bht_taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            perf_br_cnt    <= '0;
            perf_miss_cnt  <= '0;
        end else begin
            redirect_valid <= resolve && mispred;
            if (resolve)            redirect_pc   <= next_pc;
            if (resolve && is_ctrl) perf_br_cnt   <= perf_br_cnt + 32'd1;
            if (resolve && mispred) perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_bru_bp.sv
// Scoreboard bench for bru_bp: directed scenarios plus random resolves checked
// against a table-level reference model.
module tb_bru_bp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int TAG_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;
    logic [XLEN-1:0] if_pred_target;
    logic            ex_valid, ex_flush;
    logic [7:0]      ex_jump_type;
    logic [XLEN-1:0] ex_src1, ex_src2, ex_pc, ex_imm;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [31:0]     perf_br_cnt, perf_miss_cnt;

    always #5 clk = ~clk;

    bru_bp #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_jump_type(ex_jump_type), .ex_src1(ex_src1), .ex_src2(ex_src2),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .perf_br_cnt(perf_br_cnt), .perf_miss_cnt(perf_miss_cnt)
    );

    localparam bit [7:0] JAL = 8'h01, JALR = 8'h02, BEQ = 8'h04, BNE = 8'h08,
                         BLT = 8'h10, BGE = 8'h20, BLTU = 8'h40, BGEU = 8'h80;

    // Reference model: plain arrays indexed by BTB slot.
    bit        m_v   [DEPTH];
    bit [7:0]  m_tag [DEPTH];
    bit [31:0] m_tgt [DEPTH];
    bit        m_unc [DEPTH];
    int        m_ctr [DEPTH];
    int unsigned exp_br, exp_miss;

    typedef struct {
        bit          v;
        bit [31:0]   pc;
        int unsigned br;
        int unsigned miss;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int midx(input bit [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit [7:0] mtag(input bit [31:0] pc);
        return pc[15:8];
    endfunction

    task automatic m_lookup(input bit [31:0] pc, output bit t, output bit [31:0] tg);
        int  i;
        bit  hit;
        i   = midx(pc);
        hit = m_v[i] && (m_tag[i] == mtag(pc));
        t   = hit && (m_unc[i] || m_ctr[i] >= 2);
        tg  = t ? m_tgt[i] : 32'h0;
    endtask

    // Drive one cycle of inputs at the falling edge, check the fetch lookup
    // against the model, then advance the model and queue the expected redirect.
    task automatic step(input bit v, input bit f, input bit [7:0] jt,
                        input bit [31:0] s1, input bit [31:0] s2, input bit [31:0] pc,
                        input bit [31:0] imm, input bit pt, input bit [31:0] ptg,
                        input bit [31:0] ipc);
        bit        et, taken, mis, ctrl, cond, hit;
        bit [31:0] etg, tgt, npc;
        int        i;
        exp_t      e;
        @(negedge clk);
        ex_valid = v; ex_flush = f; ex_jump_type = jt; ex_src1 = s1; ex_src2 = s2;
        ex_pc = pc; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptg; if_pc = ipc;
        #1;
        if (rst) return;
        m_lookup(ipc, et, etg);
        chk("lookup_taken", if_pred_taken, et);
        chk("lookup_target", if_pred_target, etg);

        tgt = pc + imm;
        case (jt)
            JAL:  taken = 1'b1;
            JALR: begin taken = 1'b1; tgt = (s1 + imm) & ~32'h1; end
            BEQ:  taken = (s1 == s2);
            BNE:  taken = (s1 != s2);
            BLT:  taken = ($signed(s1) <  $signed(s2));
            BGE:  taken = ($signed(s1) >= $signed(s2));
            BLTU: taken = (s1 <  s2);
            BGEU: taken = (s1 >= s2);
            default: taken = 1'b0;
        endcase
        ctrl = (jt != 8'h0);
        cond = ctrl && jt != JAL && jt != JALR;
        npc  = taken ? tgt : pc + 32'd4;
        mis  = (taken != pt) || (taken && tgt != ptg);

        if (v && !f) begin
            i   = midx(pc);
            hit = m_v[i] && (m_tag[i] == mtag(pc));
            if (ctrl) exp_br++;
            if (mis)  exp_miss++;
            if (cond) m_ctr[i] = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                       : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (taken) begin
                m_v[i] = 1'b1; m_tag[i] = mtag(pc); m_tgt[i] = tgt;
                m_unc[i] = (jt == JAL || jt == JALR);
            end else if (!ctrl && hit) begin
                m_v[i] = 1'b0;
            end
        end
        e.v = v && !f && mis; e.pc = npc; e.br = exp_br; e.miss = exp_miss;
        q.push_back(e);
    endtask

    task automatic idle(input bit [31:0] ipc);
        step(1'b0, 1'b0, 8'h0, 0, 0, 0, 0, 1'b0, 0, ipc);
    endtask

    // Monitor: each queued cycle is compared one edge later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("redirect_valid", redirect_valid, e.v);
                if (e.v) chk("redirect_pc", redirect_pc, e.pc);
                chk("perf_br_cnt", perf_br_cnt, e.br);
                chk("perf_miss_cnt", perf_miss_cnt, e.miss);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit [31:0] pcs  [8] = '{32'h100, 32'h200, 32'h304, 32'h1304, 32'h308, 32'h400, 32'h10C, 32'h110};
    bit [31:0] vals [6] = '{32'h0, 32'h1, 32'h5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    bit [7:0]  jts  [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        bit        pt;
        bit [31:0] ptg, pc, s1, s2, imm;
        bit [7:0]  jt;

        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_unc[i] = 0; m_ctr[i] = 1;
        end
        exp_br = 0; exp_miss = 0;

        // A mispredicting resolve held through reset must be discarded.
        rst = 1'b1;
        step(1, 0, BEQ, 5, 5, 32'h100, 32'h40, 0, 0, 32'h100);
        step(1, 0, JAL, 0, 0, 32'h104, 32'h80, 0, 0, 32'h100);
        @(negedge clk);
        rst = 1'b0; ex_valid = 1'b0;
        #1;
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_perf_br", perf_br_cnt, 32'h0);
        chk("rst_perf_miss", perf_miss_cnt, 32'h0);

        step(1, 0, BEQ, 5, 5, 32'h100, 32'h40, 0, 0, 32'h100);
        chk("rst_lookup_0x100", if_pred_taken, 1'b0);
        idle(32'h100);
        chk("beq_learned_taken", if_pred_taken, 1'b1);
        chk("beq_learned_target", if_pred_target, 32'h140);

        step(1, 0, BGE,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10C, 32'h20, 0, 0, 32'h0);
        step(1, 0, BGEU, 32'h1, 32'hFFFF_FFFF, 32'h110, 32'h30, 1, 32'h140, 32'h0);
        step(1, 0, JALR, 32'h2001, 0, 32'h208, 32'h10, 1, 32'h2010, 32'h0);

        repeat (3) step(1, 0, BNE, 7, 7, 32'h304, 32'h80, 0, 0, 32'h304);
        step(1, 0, BNE, 7, 8, 32'h304, 32'h80, 0, 0, 32'h304);
        idle(32'h304);
        chk("bne_ctr01_not_taken", if_pred_taken, 1'b0);
        step(1, 0, BNE, 7, 8, 32'h304, 32'h80, 0, 0, 32'h304);
        idle(32'h304);
        chk("bne_ctr10_taken", if_pred_taken, 1'b1);
        chk("bne_ctr10_target", if_pred_target, 32'h384);

        step(1, 1, BEQ, 1, 1, 32'h400, 32'h40, 0, 0, 32'h400);
        idle(32'h400);
        chk("flush_no_btb_write", if_pred_taken, 1'b0);

        step(1, 0, 8'h00, 0, 0, 32'h100, 0, 1, 32'h140, 32'h100);
        idle(32'h100);
        chk("noncontrol_invalidated", if_pred_taken, 1'b0);

        for (int n = 0; n < 400; n++) begin
            pc  = pcs[$urandom_range(0, 7)];
            jt  = jts[$urandom_range(0, 8)];
            s1  = ($urandom_range(0, 3) == 0) ? $urandom() : vals[$urandom_range(0, 5)];
            s2  = ($urandom_range(0, 3) == 0) ? $urandom() : vals[$urandom_range(0, 5)];
            imm = 32'($urandom_range(0, 255)) * 32'd4 - 32'd512;
            m_lookup(pc, pt, ptg);
            if ($urandom_range(0, 3) == 0) begin
                pt  = $urandom_range(0, 1) == 1;
                ptg = $urandom_range(0, 1) == 1 ? pc + imm : $urandom();
            end
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, jt, s1, s2, pc,
                 imm, pt, ptg, pcs[$urandom_range(0, 7)]);
        end

        repeat (3) idle(32'h100);
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
